// File: rtl/wsn_mem_map_pkg.sv
// Shared node-memory map for the sink-aggregation pipeline:
// count words, table bases, word width and the update FSM states.
package wsn_mem_map_pkg;

  localparam int WORD_WIDTH = 16;

  localparam logic [15:0] ADDR_FLAG  = 16'h0002;
  localparam logic [15:0] SINK_BASE  = 16'h0008;
  localparam logic [15:0] NID_BASE   = 16'h0048;
  localparam logic [15:0] CLU_BASE   = 16'h00C8;
  localparam logic [15:0] ADDR_SCNT  = 16'h0688;
  localparam logic [15:0] ADDR_NCNT  = 16'h068A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_NCNT,
    ST_RD_SCNT,
    ST_SCAN_N,
    ST_WR_NID,
    ST_WR_CLU,
    ST_WR_NCNT,
    ST_SINK_CHK,
    ST_SCAN_S,
    ST_WR_SID,
    ST_WR_SCNT,
    ST_DONE
  } nt_state_t;

  function automatic logic [15:0] word_addr(
    input logic [15:0] base,
    input logic [15:0] idx
  );
    return base + (idx << 1);
  endfunction

endpackage

// File: rtl/neighbor_table_update.sv
// Beacon-driven neighbour / known-sink table update over shared node memory.
// Ports: clock, nrst (sync, active-low); start + src_* beacon fields in;
// data_in read data; address/wr_en/data_out memory port; done and
// new_neighbor/new_sink/overflow result flags (held in DONE).
module neighbor_table_update
  import wsn_mem_map_pkg::*;
#(
  parameter int MAX_NEIGHBORS = 64,
  parameter int MAX_SINKS     = 32
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        start,
  input  logic [15:0] src_id,
  input  logic [15:0] src_cluster,
  input  logic        src_is_sink,
  input  logic [15:0] data_in,
  output logic [15:0] address,
  output logic        wr_en,
  output logic [15:0] data_out,
  output logic        done,
  output logic        new_neighbor,
  output logic        new_sink,
  output logic        overflow
);

  localparam logic [15:0] NMAX = 16'(MAX_NEIGHBORS);
  localparam logic [15:0] SMAX = 16'(MAX_SINKS);

  typedef logic [WORD_WIDTH-1:0] word_t;

  nt_state_t state_q, state_d;
  word_t     ncnt_q, ncnt_d;
  word_t     scnt_q, scnt_d;
  word_t     idx_q, idx_d;
  word_t     sid_q, sid_d;
  word_t     sclu_q, sclu_d;
  logic      ssink_q, ssink_d;
  logic      nn_q, nn_d;
  logic      ns_q, ns_d;
  logic      ovf_q, ovf_d;

  word_t     nlim;
  word_t     slim;
  word_t     idx_inc;
  nt_state_t after_nbr;

  // Counts above capacity behave as a full table; scans stop at capacity.
  assign nlim    = (ncnt_q > NMAX) ? NMAX : ncnt_q;
  assign slim    = (scnt_q > SMAX) ? SMAX : scnt_q;
  assign idx_inc = idx_q + 16'd1;
  // Non-sink beacons skip the sink stage entirely.
  assign after_nbr = ssink_q ? ST_SINK_CHK : ST_DONE;

  always_comb begin
    state_d = state_q;
    ncnt_d  = ncnt_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    sid_d   = sid_q;
    sclu_d  = sclu_q;
    ssink_d = ssink_q;
    nn_d    = nn_q;
    ns_d    = ns_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sid_d   = src_id;
          sclu_d  = src_cluster;
          ssink_d = src_is_sink;
          nn_d    = 1'b0;
          ns_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_RD_NCNT;
        end
      end
      ST_RD_NCNT: begin
        ncnt_d  = data_in;
        state_d = ST_RD_SCNT;
      end
      ST_RD_SCNT: begin
        scnt_d  = data_in;
        idx_d   = '0;
        state_d = (ncnt_q == '0) ? ST_WR_NID : ST_SCAN_N;
      end
      ST_SCAN_N: begin
        if (data_in == sid_q) begin
          state_d = ST_WR_CLU;
        end else begin
          idx_d = idx_inc;
          if (idx_inc == nlim) state_d = ST_WR_NID;
        end
      end
      ST_WR_NID: begin
        if (ncnt_q >= NMAX) begin
          ovf_d   = 1'b1;
          state_d = after_nbr;
        end else begin
          nn_d    = 1'b1;
          idx_d   = ncnt_q;
          state_d = ST_WR_CLU;
        end
      end
      ST_WR_CLU: begin
        state_d = nn_q ? ST_WR_NCNT : after_nbr;
      end
      ST_WR_NCNT: begin
        state_d = after_nbr;
      end
      ST_SINK_CHK: begin
        if (!ssink_q) begin
          state_d = ST_DONE;
        end else if (scnt_q == '0) begin
          state_d = ST_WR_SID;
        end else begin
          idx_d   = '0;
          state_d = ST_SCAN_S;
        end
      end
      ST_SCAN_S: begin
        if (data_in == sid_q) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_inc;
          if (idx_inc == slim) state_d = ST_WR_SID;
        end
      end
      ST_WR_SID: begin
        if (scnt_q >= SMAX) begin
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          ns_d    = 1'b1;
          state_d = ST_WR_SCNT;
        end
      end
      ST_WR_SCNT: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port is a pure function of the current state and registers.
  always_comb begin
    address  = '0;
    wr_en    = 1'b0;
    data_out = '0;
    unique case (state_q)
      ST_RD_NCNT: address = ADDR_NCNT;
      ST_RD_SCNT: address = ADDR_SCNT;
      ST_SCAN_N:  address = word_addr(NID_BASE, idx_q);
      ST_WR_NID: begin
        address = word_addr(NID_BASE, ncnt_q);
        if (ncnt_q < NMAX) begin
          wr_en    = 1'b1;
          data_out = sid_q;
        end
      end
      ST_WR_CLU: begin
        address  = word_addr(CLU_BASE, idx_q);
        wr_en    = 1'b1;
        data_out = sclu_q;
      end
      ST_WR_NCNT: begin
        address  = ADDR_NCNT;
        wr_en    = 1'b1;
        data_out = ncnt_q + 16'd1;
      end
      ST_SCAN_S: address = word_addr(SINK_BASE, idx_q);
      ST_WR_SID: begin
        address = word_addr(SINK_BASE, scnt_q);
        if (scnt_q < SMAX) begin
          wr_en    = 1'b1;
          data_out = sid_q;
        end
      end
      ST_WR_SCNT: begin
        address  = ADDR_SCNT;
        wr_en    = 1'b1;
        data_out = scnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  assign done         = (state_q == ST_DONE);
  assign new_neighbor = nn_q;
  assign new_sink     = ns_q;
  assign overflow     = ovf_q;

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      ncnt_q  <= '0;
      scnt_q  <= '0;
      idx_q   <= '0;
      sid_q   <= '0;
      sclu_q  <= '0;
      ssink_q <= 1'b0;
      nn_q    <= 1'b0;
      ns_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ncnt_q  <= ncnt_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      sid_q   <= sid_d;
      sclu_q  <= sclu_d;
      ssink_q <= ssink_d;
      nn_q    <= nn_d;
      ns_q    <= ns_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_neighbor_table_update.sv
// Directed bench for neighbor_table_update with a word-addressed
// node memory that logs every strobed write.
module tb_neighbor_table_update;

  logic        clock = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_id = '0;
  logic [15:0] src_cluster = '0;
  logic        src_is_sink = 1'b0;
  logic [15:0] data_in;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic        done;
  logic        new_neighbor;
  logic        new_sink;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [0:1023];
  logic [15:0] wa[$];
  logic [15:0] wd[$];
  logic        ld_en = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] ld_a = '0;
  logic [15:0] ld_d = '0;

  always #5 clock = ~clock;

  assign data_in = mem[address[10:1]];

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (ld_en) begin
      mem[ld_a[10:1]] <= ld_d;
    end else if (wr_en) begin
      mem[address[10:1]] <= data_out;
      wa.push_back(address);
      wd.push_back(data_out);
    end
  end

  neighbor_table_update dut (
    .clock(clock), .nrst(nrst), .start(start),
    .src_id(src_id), .src_cluster(src_cluster),
    .src_is_sink(src_is_sink), .data_in(data_in),
    .address(address), .wr_en(wr_en), .data_out(data_out),
    .done(done), .new_neighbor(new_neighbor),
    .new_sink(new_sink), .overflow(overflow)
  );

  task automatic clear_mem();
    @(negedge clock); clr = 1'b1;
    @(negedge clock); clr = 1'b0;
  endtask

  task automatic put(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    ld_a = a; ld_d = d; ld_en = 1'b1;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic run(input logic [15:0] id, input logic [15:0] cl,
                     input logic sk, output int lat);
    wa.delete(); wd.delete();
    @(negedge clock);
    src_id = id; src_cluster = cl; src_is_sink = sk; start = 1'b1;
    lat = 0;
    do begin
      @(posedge clock); lat++; #1;
    end while (!done && lat < 300);
  endtask

  task automatic release_start();
    @(negedge clock); start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    @(negedge clock); nrst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (address !== 16'h0) begin n_bad++; $display("FAIL rst_address got %h want 0000", address); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
    n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL rst_data_out got %h want 0000", data_out); end
    n_cmp++; if ({done, new_neighbor, new_sink, overflow} !== 4'b0) begin
      n_bad++; $display("FAIL rst_flags got %b want 0000", {done, new_neighbor, new_sink, overflow}); end
    @(negedge clock); nrst = 1'b1;
  endtask

  task automatic test_new_empty();
    int lat;
    logic [15:0] ea[3] = '{16'h0048, 16'h00C8, 16'h068A};
    logic [15:0] ed[3] = '{16'd5, 16'd2, 16'd1};
    clear_mem();
    run(16'd5, 16'd2, 1'b0, lat);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL empty_latency got %0d want 6", lat); end
    n_cmp++; if ({done, new_neighbor, new_sink, overflow} !== 4'b1100) begin
      n_bad++; $display("FAIL empty_flags got %b want 1100", {done, new_neighbor, new_sink, overflow}); end
    n_cmp++; if (wa.size() !== 3) begin n_bad++; $display("FAIL empty_nwrites got %0d want 3", wa.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < wa.size()) begin
        n_cmp++;
        if (wa[k] !== ea[k] || wd[k] !== ed[k]) begin
          n_bad++; $display("FAIL empty_write%0d got %h<-%0d want %h<-%0d", k, wa[k], wd[k], ea[k], ed[k]);
        end
      end
    end
    // start held high: DONE must not retrigger or write again
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (done !== 1'b1 || wa.size() !== 3) begin
      n_bad++; $display("FAIL hold_start got done=%b writes=%0d want done=1 writes=3", done, wa.size()); end
    release_start();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_release got %b want 0", done); end
  endtask

  task automatic test_refresh();
    int lat;
    clear_mem();
    put(16'h068A, 16'd3);
    put(16'h0048, 16'd3);
    put(16'h004A, 16'd5);
    put(16'h004C, 16'd9);
    run(16'd9, 16'd4, 1'b0, lat);
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL refresh_latency got %0d want 7", lat); end
    n_cmp++; if ({done, new_neighbor, new_sink, overflow} !== 4'b1000) begin
      n_bad++; $display("FAIL refresh_flags got %b want 1000", {done, new_neighbor, new_sink, overflow}); end
    n_cmp++; if (wa.size() !== 1) begin n_bad++; $display("FAIL refresh_nwrites got %0d want 1", wa.size()); end
    if (wa.size() > 0) begin
      n_cmp++;
      if (wa[0] !== 16'h00CC || wd[0] !== 16'd4) begin
        n_bad++; $display("FAIL refresh_write got %h<-%0d want 00cc<-4", wa[0], wd[0]);
      end
    end
    release_start();
  endtask

  task automatic test_new_sink();
    int lat;
    logic [15:0] ea[5] = '{16'h004A, 16'h00CA, 16'h068A, 16'h000A, 16'h0688};
    logic [15:0] ed[5] = '{16'd8, 16'd6, 16'd2, 16'd8, 16'd2};
    clear_mem();
    put(16'h068A, 16'd1);
    put(16'h0688, 16'd1);
    put(16'h0048, 16'd3);
    put(16'h0008, 16'd7);
    run(16'd8, 16'd6, 1'b1, lat);
    n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL sink_latency got %0d want 11", lat); end
    n_cmp++; if ({done, new_neighbor, new_sink, overflow} !== 4'b1110) begin
      n_bad++; $display("FAIL sink_flags got %b want 1110", {done, new_neighbor, new_sink, overflow}); end
    n_cmp++; if (wa.size() !== 5) begin n_bad++; $display("FAIL sink_nwrites got %0d want 5", wa.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < wa.size()) begin
        n_cmp++;
        if (wa[k] !== ea[k] || wd[k] !== ed[k]) begin
          n_bad++; $display("FAIL sink_write%0d got %h<-%0d want %h<-%0d", k, wa[k], wd[k], ea[k], ed[k]);
        end
      end
    end
    release_start();
  endtask

  task automatic test_known_sink();
    int lat;
    clear_mem();
    put(16'h068A, 16'd1);
    put(16'h0688, 16'd1);
    put(16'h0048, 16'd7);
    put(16'h0008, 16'd7);
    run(16'd7, 16'd3, 1'b1, lat);
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL known_latency got %0d want 7", lat); end
    n_cmp++; if ({done, new_neighbor, new_sink, overflow} !== 4'b1000) begin
      n_bad++; $display("FAIL known_flags got %b want 1000", {done, new_neighbor, new_sink, overflow}); end
    n_cmp++; if (wa.size() !== 1) begin n_bad++; $display("FAIL known_nwrites got %0d want 1", wa.size()); end
    if (wa.size() > 0) begin
      n_cmp++;
      if (wa[0] !== 16'h00C8 || wd[0] !== 16'd3) begin
        n_bad++; $display("FAIL known_write got %h<-%0d want 00c8<-3", wa[0], wd[0]);
      end
    end
    release_start();
  endtask

  task automatic test_nbr_overflow();
    int lat;
    clear_mem();
    // count above capacity; a match planted just past the table end
    put(16'h068A, 16'd200);
    for (int k = 0; k < 64; k++) put(16'(16'h0048 + 2 * k), 16'(100 + k));
    put(16'h00C8, 16'd5);
    run(16'd5, 16'd1, 1'b0, lat);
    n_cmp++; if (lat !== 68) begin n_bad++; $display("FAIL novf_latency got %0d want 68", lat); end
    n_cmp++; if ({done, new_neighbor, new_sink, overflow} !== 4'b1001) begin
      n_bad++; $display("FAIL novf_flags got %b want 1001", {done, new_neighbor, new_sink, overflow}); end
    n_cmp++; if (wa.size() !== 0) begin n_bad++; $display("FAIL novf_nwrites got %0d want 0", wa.size()); end
    release_start();
  endtask

  task automatic test_sink_overflow();
    int lat;
    clear_mem();
    put(16'h068A, 16'd1);
    put(16'h0688, 16'd32);
    put(16'h0048, 16'd50);
    for (int k = 0; k < 32; k++) put(16'(16'h0008 + 2 * k), 16'(200 + k));
    run(16'd50, 16'd9, 1'b1, lat);
    n_cmp++; if (lat !== 39) begin n_bad++; $display("FAIL sovf_latency got %0d want 39", lat); end
    n_cmp++; if ({done, new_neighbor, new_sink, overflow} !== 4'b1001) begin
      n_bad++; $display("FAIL sovf_flags got %b want 1001", {done, new_neighbor, new_sink, overflow}); end
    n_cmp++; if (wa.size() !== 1) begin n_bad++; $display("FAIL sovf_nwrites got %0d want 1", wa.size()); end
    if (wa.size() > 0) begin
      n_cmp++;
      if (wa[0] !== 16'h00C8 || wd[0] !== 16'd9) begin
        n_bad++; $display("FAIL sovf_write got %h<-%0d want 00c8<-9", wa[0], wd[0]);
      end
    end
    release_start();
  endtask

  task automatic test_reset_mid();
    clear_mem();
    put(16'h068A, 16'd3);
    put(16'h0048, 16'd1);
    put(16'h004A, 16'd2);
    put(16'h004C, 16'd3);
    wa.delete(); wd.delete();
    @(negedge clock);
    src_id = 16'd9; src_cluster = 16'd1; src_is_sink = 1'b0; start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (address !== 16'h0048) begin n_bad++; $display("FAIL mid_scan_addr got %h want 0048", address); end
    @(negedge clock); nrst = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (address !== 16'h0 || wr_en !== 1'b0 || data_out !== 16'h0) begin
      n_bad++; $display("FAIL mid_rst_port got a=%h we=%b d=%h want 0000/0/0000", address, wr_en, data_out); end
    n_cmp++; if ({done, new_neighbor, new_sink, overflow} !== 4'b0) begin
      n_bad++; $display("FAIL mid_rst_flags got %b want 0000", {done, new_neighbor, new_sink, overflow}); end
    @(negedge clock); start = 1'b0; nrst = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    n_cmp++; if (wa.size() !== 0 || address !== 16'h0) begin
      n_bad++; $display("FAIL mid_rst_idle got writes=%0d a=%h want 0/0000", wa.size(), address); end
  endtask

  initial begin
    test_reset();
    test_new_empty();
    test_refresh();
    test_new_sink();
    test_known_sink();
    test_nbr_overflow();
    test_sink_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
